// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmit path.
// FSM encoding and common divisor constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_MIN_DIV          = 2;
    localparam int UART_DIV_115200_50MHZ = 434;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// Head entry is visible on rdata whenever count is non-zero.
module uart_tx_fifo #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 push,
    input  logic                 pop,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]           mem_q [DEPTH];
    logic [PW-1:0]        wr_q;
    logic [PW-1:0]        rd_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 push_ok;
    logic                 pop_ok;

    assign push_ok = push && (cnt_q != CNT_WIDTH'(DEPTH));
    assign pop_ok  = pop && (cnt_q != '0);
    assign rdata   = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter with a stream input and a byte FIFO.
// Frames chain directly from STOP into START when data is waiting.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] fifo_count
);
    localparam int BW = $clog2(UART_DATA_BITS);

    uart_state_e          state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic [DIV_WIDTH-1:0] baud_q;
    logic [BW-1:0]        bit_q;
    logic [7:0]           sh_q;
    logic                 tx_q;
    logic [7:0]           head;
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 nonempty;

    assign in_ready = (fifo_count != CNT_WIDTH'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign nonempty = (fifo_count != '0);
    assign tick     = (baud_q == '0);
    assign div_d    = (baud_div < DIV_WIDTH'(UART_MIN_DIV)) ?
                      DIV_WIDTH'(UART_MIN_DIV) : baud_div;
    assign pop      = nonempty &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_STOP) && tick));
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || nonempty;

    uart_tx_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clock (clock),
        .resetb(resetb),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else if (pop) begin
            // Divisor is sampled once here and held for the whole frame.
            state_q <= ST_START;
            sh_q    <= head;
            div_q   <= div_d;
            baud_q  <= div_d - 1'b1;
            bit_q   <= '0;
            tx_q    <= 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (!tick) begin
                baud_q <= baud_q - 1'b1;
            end else begin
                baud_q <= div_q - 1'b1;
                unique case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        tx_q    <= sh_q[0];
                    end
                    ST_DATA: begin
                        if (bit_q == BW'(UART_DATA_BITS - 1)) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            sh_q  <= {1'b0, sh_q[7:1]};
                            tx_q  <= sh_q[1];
                        end
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: a line receiver decodes frames
// and each scenario task checks bytes, frame shape and busy time.
module tb_uart_tx_stream;

    typedef logic [7:0] byte_q_t[$];

    logic        clock;
    logic        resetb;
    logic [15:0] baud_div;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_cmp;
    int n_fail;
    int busy_cnt;
    int rd_idx;
    bit mon_en;
    int mon_div;
    logic [7:0] rx_q[$];
    int bad_q[$];

    uart_tx_stream #(
        .DIV_WIDTH (16),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (3)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .baud_div  (baud_div),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    // Line receiver: records each frame cycle by cycle, decodes the byte
    // from mid-bit samples and counts cycles deviating from an ideal frame.
    initial begin : monitor
        int d;
        int bad;
        logic [7:0] got;
        logic smp[$];
        logic want_bit;
        forever begin
            @(negedge clock);
            if (mon_en && resetb === 1'b1 && tx === 1'b0) begin
                d = mon_div;
                smp.delete();
                smp.push_back(tx);
                for (int k = 1; k < 10 * d; k++) begin
                    @(negedge clock);
                    smp.push_back(tx);
                end
                got = '0;
                for (int i = 0; i < 8; i++) got[i] = smp[(i + 1) * d + d / 2];
                bad = 0;
                for (int k = 0; k < 10 * d; k++) begin
                    if (k < d) want_bit = 1'b0;
                    else if (k >= 9 * d) want_bit = 1'b1;
                    else want_bit = got[k / d - 1];
                    if (smp[k] !== want_bit) bad++;
                end
                rx_q.push_back(got);
                bad_q.push_back(bad);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int w = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 20000) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int base, input int exp_busy);
        int w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (busy !== 1'b0 && w < 60000);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", nm, busy, w);
        end else if (exp_busy >= 0) begin
            n_cmp++;
            if (busy_cnt - base != exp_busy) begin
                n_fail++;
                $display("FAIL %s_busy: got %0d busy cycles, required %0d",
                         nm, busy_cnt - base, exp_busy);
            end
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic check_rx(input string nm, input byte_q_t want);
        int avail = rx_q.size() - rd_idx;
        n_cmp++;
        if (avail != want.size()) begin
            n_fail++;
            $display("FAIL %s_frames: got %0d frames, required %0d", nm, avail, want.size());
        end
        for (int i = 0; i < want.size() && i < avail; i++) begin
            n_cmp += 2;
            if (rx_q[rd_idx + i] !== want[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %h, required %h",
                         nm, i, rx_q[rd_idx + i], want[i]);
            end
            if (bad_q[rd_idx + i] != 0) begin
                n_fail++;
                $display("FAIL %s_wave%0d: %0d cycles off, required 0",
                         nm, i, bad_q[rd_idx + i]);
            end
        end
        rd_idx = rx_q.size();
    endtask

    task automatic test_reset;
        bit ok = 1'b1;
        resetb   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        baud_div = 16'd434;
        repeat (3) @(negedge clock);
        n_cmp += 4;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_tx: got %b, required 1", tx);
        end
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready: got %b, required 1", in_ready);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: got %b, required 0", busy);
        end
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_count: got %0d, required 0", fifo_count);
        end
        resetb = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (tx !== 1'b1) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_idle_tx: tx left 1 while idle, required 1");
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single;
        byte_q_t want;
        int base = busy_cnt;
        want     = '{8'h37};
        baud_div = 16'd434;
        mon_div  = 434;
        in_valid = 1'b1;
        in_data  = 8'h37;
        @(posedge clock);
        #1;
        n_cmp += 2;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_edge1_tx: got %b, required 1", tx);
        end
        if (fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL lat_edge1_count: got %0d, required 1", fifo_count);
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        n_cmp += 2;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_edge2_tx: got %b, required 0", tx);
        end
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL lat_edge2_count: got %0d, required 0", fifo_count);
        end
        wait_idle("single", base, 4341);
        check_rx("single", want);
    endtask

    task automatic test_back_to_back;
        byte_q_t want;
        int base = busy_cnt;
        want     = '{8'h55, 8'hA3};
        baud_div = 16'd4;
        mon_div  = 4;
        send(8'h55);
        send(8'hA3);
        wait_idle("b2b", base, 81);
        check_rx("b2b", want);
    endtask

    task automatic test_full;
        byte_q_t want;
        int base = busy_cnt;
        baud_div = 16'd8;
        mon_div  = 8;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i));
            want.push_back(8'(i));
        end
        n_cmp += 2;
        if (fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_count: got %0d, required 4", fifo_count);
        end
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b, required 0", in_ready);
        end
        send(8'h06);
        want.push_back(8'h06);
        wait_idle("full", base, 481);
        check_rx("full", want);
    endtask

    task automatic test_div_edges;
        for (int raw = 0; raw < 2; raw++) begin
            byte_q_t want;
            logic [7:0] b = 8'($urandom);
            int base = busy_cnt;
            want.push_back(b);
            baud_div = 16'(raw);
            mon_div  = 2;
            send(b);
            wait_idle("div_small", base, 21);
            check_rx("div_small", want);
        end
    endtask

    task automatic test_div_change;
        byte_q_t want;
        int base = busy_cnt;
        want.push_back(8'($urandom));
        want.push_back(8'($urandom));
        baud_div = 16'd4;
        mon_div  = 4;
        send(want[0]);
        send(want[1]);
        repeat (14) @(negedge clock);
        baud_div = 16'd10;
        mon_div  = 10;
        wait_idle("div_change", base, 141);
        check_rx("div_change", want);
    endtask

    task automatic test_random;
        for (int batch = 0; batch < 3; batch++) begin
            byte_q_t want;
            int raw = $urandom_range(0, 6);
            baud_div = 16'(raw);
            mon_div  = (raw < 2) ? 2 : raw;
            for (int i = 0; i < 5; i++) begin
                logic [7:0] b = 8'($urandom);
                repeat ($urandom_range(0, 25)) @(negedge clock);
                send(b);
                want.push_back(b);
            end
            wait_idle("random", 0, -1);
            check_rx("random", want);
        end
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b1;
        mon_en   = 1'b0;
        baud_div = 16'd4;
        send(8'h81);
        send(8'h42);
        send(8'h24);
        repeat (16) @(negedge clock);
        n_cmp++;
        if (fifo_count !== 3'd2) begin
            n_fail++;
            $display("FAIL mid_queued: got %0d, required 2", fifo_count);
        end
        resetb = 1'b0;
        #1;
        n_cmp += 4;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_tx: got %b, required 1", tx);
        end
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_rst_count: got %0d, required 0", fifo_count);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_busy: got %b, required 0", busy);
        end
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_ready: got %b, required 1", in_ready);
        end
        @(negedge clock);
        resetb = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_after: line or busy active after reset, required idle");
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        busy_cnt = 0;
        rd_idx   = 0;
        mon_en   = 1'b0;
        mon_div  = 2;
        test_reset;
        test_single;
        test_back_to_back;
        test_full;
        test_div_edges;
        test_div_change;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Synthesizable 8N1 UART transmitter with a small byte FIFO.
- Serializes bytes pushed over a valid/ready stream onto a single TX line at a programmable baud divisor.
- Drives the Microwatt/management UART RX pin (mprj_io[5]) from user-area logic and bench stimulus.
- Replaces hand-timed bit-banging and is the transmit counterpart to the existing serial receive checkers.

Parameters:
- DIV_WIDTH, 16, width of the baud divisor input.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 3, width of fifo_count; must satisfy 2^CNT_WIDTH > FIFO_DEPTH.

Ports:
- clock  input  1  system clock; all state is on its rising edge.
- resetb  input  1  asynchronous, active-low reset.
- baud_div  input  DIV_WIDTH  clock cycles per bit; values below 2 are treated as 2.
- in_valid  input  1  byte offered.
- in_data  input  8  byte to transmit.
- in_ready  output  1  FIFO can accept a byte.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  output  CNT_WIDTH  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, `clock`; reset `resetb` is asynchronous and active-low.
- Reset values: tx=1, in_ready=1, busy=0, fifo_count=0, FSM=IDLE, all counters 0, FIFO emptied.
- Deassertion of resetb is not synchronized internally; the integrator synchronizes it.
- Handshake:
  - A byte is accepted on a rising edge with in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from registered state.
  - in_data may change freely while in_ready=0.
- Simultaneous push and pop: when FIFO is full, a pop in the same cycle does not make in_ready high that cycle; fifo_count is unchanged; both operations take effect.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If FIFO is non-empty, pop the head into shift register sh[7:0], latch div_l = max(baud_div, 2), clear bit counter, go to START. tx falls on the cycle after the pop.
  - START: tx=0 for div_l cycles, then DATA.
  - DATA: tx=sh[0] for div_l cycles, then shift right. After 8 bits (bit counter 7→wrap), go to STOP. LSB is sent first.
  - STOP: tx=1 for div_l cycles. If the FIFO is non-empty at the end of stop, pop directly and enter START with no idle gap (back-to-back frames); otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*div_l cycles, plus one IDLE cycle only when starting from IDLE.
  - Latency from the accepting edge (FIFO empty, FSM idle) to tx falling: 2 clock edges.
- Baud counter: counts div_l-1 down to 0; reloads at 0 and advances state. div_l is held for the whole frame; baud_div changes take effect at the next frame start.
- tx is driven from a flop; no combinational path from inputs to tx.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: tx returns high immediately (asynchronously). The frame is truncated and the FIFO contents are discarded.
- FIFO: circular read/write pointers of width log2(FIFO_DEPTH), wrap naturally; empty/full derived from fifo_count.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - UART_DATA_BITS=8, UART_MIN_DIV=2.
  - Divisor constant UART_DIV_115200_50MHZ=434.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/count, same clock and reset. The top holds the FSM, baud counter, and shift register.

Test Plan:
- Reset: hold resetb=0 → tx=1, in_ready=1, busy=0, fifo_count=0. Release and idle 100 cycles → tx stays 1.
- Single byte: baud_div=434, push 0x37 → tx low 434 cycles, then bits 1,1,1,0,1,1,0,0 at 434 cycles each, stop high 434. A bench receiver decodes '7'. busy drops after 4340+1 cycles.
- Back-to-back: baud_div=4, push 0x55 then 0xA3 on consecutive cycles → stop of frame 1 is followed immediately by start of frame 2. Total busy = 81 cycles. Decoded sequence is 0x55, 0xA3.
- Full FIFO: baud_div=8, hold in_valid with bytes 0x01..0x06 → in_ready deasserts once fifo_count=4 (the first byte already popped). The remaining bytes are accepted as frames drain. All 6 arrive in order.
- Divisor edge cases:
  - baud_div=0 and baud_div=1 → bit period 2 cycles.
  - Change baud_div from 4 to 10 mid-frame → current frame keeps 4; next frame uses 10.
- Reset mid-frame: assert resetb during DATA bit 3 with 2 bytes queued → tx=1 the same time step, fifo_count=0, busy=0. After release, no further frames.
